// File: rtl/mux81_pkg.sv
// Shared types and helpers for the mux81f channel scanner.
package mux81_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int unsigned DWELL_DEFAULT = 2;

    // mux81f decodes its select LSB-first, so channel k is driven as bit-reversed k
    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/mux81_scan_if.sv
// Scan request/abort, sampled mux output, and scan results between scanner and its host.
interface mux81_scan_if;
    logic       start;
    logic       stop;
    logic       o;
    logic [2:0] s;
    logic       busy;
    logic       done;
    logic [7:0] dato;

    modport master (output start, stop, o, input s, busy, done, dato);
    modport slave  (input start, stop, o, output s, busy, done, dato);
endinterface

// File: rtl/mux81_dwell_cnt.sv
// Settle timer: 4-bit up-counter with clear/enable; term flags the last settle cycle.
module mux81_dwell_cnt #(
    parameter int unsigned DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [3:0] TERM_VAL = (DWELL == 0) ? 4'd0 : 4'(DWELL - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 4'd1;
    end

    assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/mux81_scan.sv
// Walks s across all eight mux81f channels, settles DWELL cycles each, and captures o into dato.
import mux81_pkg::*;

module mux81_scan #(
    parameter int unsigned DWELL = mux81_pkg::DWELL_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    mux81_scan_if.slave     bus
);

    localparam state_t FIRST_ST = (DWELL == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t     state, state_nxt;
    logic [2:0] ch, ch_nxt;
    logic [7:0] shadow;
    logic [7:0] dato_q;
    logic [2:0] s_q, s_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;
    logic       term;
    logic       cnt_clr;
    logic       cnt_en;
    logic       capture;

    mux81_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .term (term)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (bus.start) state_nxt = FIRST_ST;
            ST_SETTLE: begin
                if (bus.stop)  state_nxt = ST_IDLE;
                else if (term) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.stop)          state_nxt = ST_IDLE;
                else if (ch == 3'd7)   state_nxt = ST_DONE;
                else                   state_nxt = FIRST_ST;
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port leaves a flop.
    always_comb begin
        ch_nxt = ch;
        if (state == ST_IDLE)
            ch_nxt = '0;
        else if (state == ST_SAMPLE && state_nxt == FIRST_ST)
            ch_nxt = ch + 3'd1;

        busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
        done_nxt = (state_nxt == ST_DONE);
        s_nxt    = busy_nxt ? bitrev3(ch_nxt) : '0;

        cnt_clr  = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);
        cnt_en   = (state == ST_SETTLE);
        capture  = (state == ST_SAMPLE) && !bus.stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch     <= '0;
            shadow <= '0;
            dato_q <= '0;
            s_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ch     <= ch_nxt;
            s_q    <= s_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            if (capture)
                shadow[ch] <= bus.o;
            // The last channel's bit is merged directly; shadow only updates at this same edge.
            if (capture && ch == 3'd7)
                dato_q <= {bus.o, shadow[6:0]};
        end
    end

    assign bus.s    = s_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dato = dato_q;

endmodule

// File: tb/tb_mux81_scan.sv
// Drives two scanners (DWELL=2 and DWELL=0) in lockstep against a timeline-based reference model.
module tb_mux81_scan;

    logic       clk;
    logic       rst;
    logic [7:0] in_vec;

    int unsigned checks;
    int unsigned passed;
    int unsigned fails;

    mux81_scan_if bus_d2 ();
    mux81_scan_if bus_d0 ();

    mux81_scan #(.DWELL(2)) u_d2 (.clk(clk), .rst(rst), .bus(bus_d2));
    mux81_scan #(.DWELL(0)) u_d0 (.clk(clk), .rst(rst), .bus(bus_d0));

    function automatic logic [2:0] rev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // mux81f behaviour: input k is routed when s = bitrev(k)
    assign bus_d2.o = in_vec[rev3(bus_d2.s)];
    assign bus_d0.o = in_vec[rev3(bus_d0.s)];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: n = cycles elapsed since the start edge; channel k owns cycles k*(D+1)+1 .. (k+1)*(D+1)
    int unsigned dw[2] = '{2, 0};
    bit          m_act[2];
    bit          m_done[2];
    int unsigned m_n[2];
    logic [7:0]  m_part[2];
    logic [7:0]  m_dato[2];

    task automatic model_edge(input int i, input logic st, input logic sp, input logic rs);
        int unsigned per, k;
        per = dw[i] + 1;
        if (rs) begin
            m_act[i] = 0; m_done[i] = 0; m_n[i] = 0;
            m_dato[i] = '0; m_part[i] = '0;
        end else if (m_act[i]) begin
            if (sp) begin
                m_act[i] = 0;
            end else begin
                k = (m_n[i] - 1) / per;
                if (m_n[i] % per == 0)
                    m_part[i][k] = in_vec[k];
                if (m_n[i] == 8 * per) begin
                    m_dato[i] = m_part[i];
                    m_act[i]  = 0;
                    m_done[i] = 1;
                end else begin
                    m_n[i]++;
                end
            end
        end else if (m_done[i]) begin
            m_done[i] = 0;
        end else if (st) begin
            m_act[i] = 1;
            m_n[i]   = 1;
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s dwell=%0d got %h expected %h", tag, dw[i], got, exp);
        end
    endtask

    function automatic logic [7:0] exp_s(input int i);
        int unsigned k;
        if (!m_act[i]) return 8'h00;
        k = (m_n[i] - 1) / (dw[i] + 1);
        return {5'b0, rev3(3'(k))};
    endfunction

    task automatic check_all();
        chk("busy", 0, {7'b0, bus_d2.busy}, {7'b0, m_act[0]});
        chk("done", 0, {7'b0, bus_d2.done}, {7'b0, m_done[0]});
        chk("dato", 0, bus_d2.dato, m_dato[0]);
        if (!m_done[0]) chk("s", 0, {5'b0, bus_d2.s}, exp_s(0));
        chk("busy", 1, {7'b0, bus_d0.busy}, {7'b0, m_act[1]});
        chk("done", 1, {7'b0, bus_d0.done}, {7'b0, m_done[1]});
        chk("dato", 1, bus_d0.dato, m_dato[1]);
        if (!m_done[1]) chk("s", 1, {5'b0, bus_d0.s}, exp_s(1));
    endtask

    task automatic step(input logic st, input logic sp, input logic rs);
        bus_d2.start = st; bus_d0.start = st;
        bus_d2.stop  = sp; bus_d0.stop  = sp;
        rst = rs;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, st, sp, rs);
        #1;
        check_all();
    endtask

    initial begin
        checks = 0; passed = 0; fails = 0;
        in_vec = 8'h4D;
        bus_d2.start = 0; bus_d2.stop = 0;
        bus_d0.start = 0; bus_d0.stop = 0;
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_done[i] = 0; m_n[i] = 0; m_part[i] = '0; m_dato[i] = '0;
        end

        repeat (2) step(0, 0, 1);

        // a..h = 1,0,1,1,0,0,1,0
        step(1, 0, 0);
        repeat (24) step(0, 0, 0);
        chk("done_cycle25", 0, {7'b0, bus_d2.done}, 8'h01);
        chk("dato_4d", 0, bus_d2.dato, 8'h4D);
        repeat (2) step(0, 0, 0);

        // DWELL=0, all ones
        in_vec = 8'hFF;
        step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        chk("done_cycle9", 1, {7'b0, bus_d0.done}, 8'h01);
        chk("dato_ff", 1, bus_d0.dato, 8'hFF);
        repeat (18) step(0, 0, 0);

        // start re-asserted while channel 3 is being scanned
        in_vec = 8'h96;
        step(1, 0, 0);
        repeat (9) step(0, 0, 0);
        repeat (3) step(1, 0, 0);
        repeat (12) step(0, 0, 0);
        chk("restart_done", 0, {7'b0, bus_d2.done}, 8'h01);
        chk("restart_dato", 0, bus_d2.dato, 8'h96);
        repeat (12) step(0, 0, 0);

        // stop in the SAMPLE cycle of channel 5
        in_vec = 8'h3C;
        step(1, 0, 0);
        repeat (17) step(0, 0, 0);
        step(0, 1, 0);
        chk("stop_busy", 0, {7'b0, bus_d2.busy}, 8'h00);
        chk("stop_s", 0, {5'b0, bus_d2.s}, 8'h00);
        chk("stop_dato", 0, bus_d2.dato, 8'h96);
        repeat (10) step(0, 0, 0);

        // reset during SETTLE of channel 2, then a clean scan
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        step(0, 0, 1);
        chk("rst_dato", 0, bus_d2.dato, 8'h00);
        step(1, 0, 0);
        repeat (24) step(0, 0, 0);
        chk("post_rst_dato", 0, bus_d2.dato, 8'h3C);
        repeat (2) step(0, 0, 0);

        // start+stop together in IDLE, then stop during DONE
        in_vec = 8'hA5;
        step(1, 1, 0);
        repeat (24) step(0, 0, 0);
        chk("ss_done", 0, {7'b0, bus_d2.done}, 8'h01);
        step(0, 1, 0);
        chk("ss_dato", 0, bus_d2.dato, 8'hA5);
        repeat (2) step(0, 0, 0);

        // randomized traffic, inputs may change at any cycle
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) in_vec = 8'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux81_scan.md
MUX81_SCAN -- requirements
Module: mux81_scan

Interface
REQ-001 Parameter: DWELL, default 2, number of settle cycles per channel before sampling (legal 0..15).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  scan request, sampled only in IDLE.
REQ-005 Port: stop  input  1  synchronous abort of a scan in progress.
REQ-006 Port: o  input  1  sampled output of the mux81f stage being scanned.
REQ-007 Port: s  output  3  select driven to mux81f.
REQ-008 Port: busy  output  1  high while a scan is in progress (SETTLE or SAMPLE).
REQ-009 Port: done  output  1  one-cycle pulse when a complete 8-channel word is published.
REQ-010 Port: dato  output  8  last completed scan word; dato[k] = mux81f input k (a=0 ... h=7).

Function
REQ-011 Channel k SHALL be selected by driving s = {k[0],k[1],k[2]} (bit-reversed k), matching mux81f decode (a: s=000, b: s=100, ..., h: s=111).
REQ-012 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-013 IDLE: start=1 at an edge SHALL set ch=0, s=bitrev(0), cnt=0, next state SETTLE if DWELL>0, else SAMPLE.
REQ-014 SETTLE: cnt increments each cycle; when cnt==DWELL-1 the next state SHALL be SAMPLE.
REQ-015 SAMPLE (exactly one cycle): at its closing edge o SHALL be captured into shadow bit ch.
REQ-016 SAMPLE with ch<7: ch increments, s=bitrev(ch+1), cnt=0, next state SETTLE (or SAMPLE if DWELL=0).
REQ-017 SAMPLE with ch=7: dato SHALL load the full shadow word, including the bit captured at that edge; next state DONE.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE; start during DONE SHALL be ignored.
REQ-019 Each channel SHALL hold s for exactly DWELL+1 cycles; done SHALL be high in the cycle after edge 8*(DWELL+1) counted from the start edge.
REQ-020 busy SHALL be 1 in SETTLE and SAMPLE, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-021 start while busy SHALL be ignored and SHALL NOT restart the scan.
REQ-022 stop=1 in SETTLE or SAMPLE SHALL force IDLE at the next edge: no done pulse, dato unchanged, s=000.
REQ-023 stop has priority over start and over SAMPLE capture in the same cycle; stop in IDLE or DONE SHALL have no effect.
REQ-024 In IDLE, s SHALL remain at 000.
REQ-025 dato SHALL change only on the SAMPLE(ch=7)->DONE edge or on reset.

Reset
REQ-026 rst=1 at an edge SHALL set state=IDLE, s=000, busy=0, done=0, dato=00h, ch=0, cnt=0, shadow=00h.
REQ-027 rst SHALL override start and stop; reset mid-scan SHALL discard the partial word.

Structure
REQ-028 Package mux81_pkg SHALL hold the state enumeration, DWELL default constant, and bitrev3 function.
REQ-029 One sub-module, mux81_dwell_cnt (4-bit counter with clear, enable, and terminal flag at DWELL-1), SHALL implement the settle timer.
REQ-030 All outputs SHALL be registered; no combinational path from o to any output.

Verification
REQ-031 DWELL=2, inputs a..h = 1,0,1,1,0,0,1,0, pulse start -> s sequence 000,100,010,110,001,101,011,111, each held 3 cycles; done in cycle 25 after start; dato=4Dh.
REQ-032 DWELL=0, all inputs 1, start -> s changes every cycle; done in cycle 9; dato=FFh; busy high for cycles 1..8.
REQ-033 Start again mid-scan at channel 3 -> no restart; s order and done timing identical to REQ-031.
REQ-034 stop asserted in the SAMPLE cycle of channel 5 -> IDLE next cycle, s=000, no done, dato keeps previous value.
REQ-035 rst asserted during SETTLE of channel 2 -> all outputs reset next cycle, dato=00h; a following start completes a normal scan.
REQ-036 start and stop asserted together in IDLE -> scan starts; stop asserted in DONE -> done pulse and dato update unaffected.
